// File: rtl/nanorv32_dma_copy.sv
// Word-granular memory-to-memory copy engine: reads one word, writes it back,
// repeats until the count runs out or an abort is pending.
module nanorv32_dma_copy #(
  parameter int NANORV32_ADDR_MSB = 31,
  parameter int NANORV32_DATA_MSB = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NANORV32_ADDR_MSB:0] src_addr,
  input  logic [NANORV32_ADDR_MSB:0] dst_addr,
  input  logic [15:0]                len_words,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                words_left,
  output logic                       dma_mem_req,
  output logic [NANORV32_ADDR_MSB:0] dma_mem_addr,
  output logic [3:0]                 dma_mem_bytesel,
  output logic [NANORV32_DATA_MSB:0] dma_mem_wdata,
  input  logic [NANORV32_DATA_MSB:0] mem_dma_rdata,
  input  logic                       mem_dma_ack
);

  localparam int AW = NANORV32_ADDR_MSB + 1;
  localparam int DW = NANORV32_DATA_MSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [15:0]     words_q, words_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            abort_q, abort_d;

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    words_d         = words_q;
    buf_d           = buf_q;
    abort_d         = abort_q;
    dma_mem_req     = 1'b0;
    dma_mem_addr    = '0;
    dma_mem_bytesel = 4'h0;
    busy            = 1'b0;
    done            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr & ~AW'(3);
          dst_d   = dst_addr & ~AW'(3);
          words_d = len_words;
          state_d = (len_words != 16'd0) ? ST_RD : ST_DONE;
        end
      end
      ST_RD: begin
        busy         = 1'b1;
        dma_mem_req  = 1'b1;
        dma_mem_addr = src_q;
        if (abort) abort_d = 1'b1;
        if (mem_dma_ack) begin
          buf_d   = mem_dma_rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        busy            = 1'b1;
        dma_mem_req     = 1'b1;
        dma_mem_addr    = dst_q;
        dma_mem_bytesel = 4'hF;
        if (abort) abort_d = 1'b1;
        if (mem_dma_ack) begin
          src_d   = src_q + AW'(4);
          dst_d   = dst_q + AW'(4);
          words_d = words_q - 16'd1;
          // An abort arriving in the acking cycle itself still ends the copy here.
          state_d = (words_q == 16'd1 || abort_q || abort) ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dma_mem_wdata = buf_q;
  assign words_left    = words_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      words_q <= '0;
      buf_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      words_q <= words_d;
      buf_q   <= buf_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_nanorv32_dma_copy.sv
// Scoreboarded bench for nanorv32_dma_copy with a registered-read /
// combinational-write memory responder.
module tb_nanorv32_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done;
  logic [15:0] words_left;
  logic        dma_mem_req;
  logic [31:0] dma_mem_addr;
  logic [3:0]  dma_mem_bytesel;
  logic [31:0] dma_mem_wdata;
  logic [31:0] mem_dma_rdata;
  logic        mem_dma_ack;

  nanorv32_dma_copy #(
    .NANORV32_ADDR_MSB(31),
    .NANORV32_DATA_MSB(31)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len_words      (len_words),
    .busy           (busy),
    .done           (done),
    .words_left     (words_left),
    .dma_mem_req    (dma_mem_req),
    .dma_mem_addr   (dma_mem_addr),
    .dma_mem_bytesel(dma_mem_bytesel),
    .dma_mem_wdata  (dma_mem_wdata),
    .mem_dma_rdata  (mem_dma_rdata),
    .mem_dma_ack    (mem_dma_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory model and responder
  logic [31:0] mem [logic [31:0]];
  int          stall_cfg = 0;
  int          stall_cnt;
  logic        rd_ack;
  logic [31:0] rd_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      stall_cnt <= 0;
    end else begin
      rd_ack <= 1'b0;
      if (dma_mem_req && dma_mem_bytesel == 4'h0 && !rd_ack) begin
        if (stall_cnt >= stall_cfg) begin
          rd_ack    <= 1'b1;
          rd_data   <= mem[dma_mem_addr];
          stall_cnt <= 0;
        end else begin
          stall_cnt <= stall_cnt + 1;
        end
      end
    end
  end

  assign mem_dma_ack   = rd_ack | (dma_mem_req && dma_mem_bytesel == 4'hF);
  assign mem_dma_rdata = rd_data;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] rd_log[$];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_pend_addr = '0;

  // Bus monitor: read-hold stability, read log, write scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend)
        check_eq("rd_hold", {27'd0, dma_mem_req, dma_mem_bytesel, dma_mem_addr},
                 {27'd0, 1'b1, 4'h0, rd_pend_addr});
      rd_pend = 1'b0;
      if (dma_mem_req && dma_mem_bytesel == 4'h0) begin
        if (mem_dma_ack) rd_log.push_back(dma_mem_addr);
        else begin
          rd_pend      = 1'b1;
          rd_pend_addr = dma_mem_addr;
        end
      end
      if (dma_mem_req && dma_mem_bytesel == 4'hF && mem_dma_ack) begin
        mem[dma_mem_addr] = dma_mem_wdata;
        check_eq("sb_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check_eq("wr_addr", 64'(dma_mem_addr), 64'(e.a));
          check_eq("wr_data", 64'(dma_mem_wdata), 64'(e.d));
        end
      end
    end
  end

  task automatic fill(input logic [31:0] base, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) mem[base + 32'(4 * i)] = seed + 32'(i) * 32'h0101_1111;
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                          input int n_exp, input int abort_cyc, input int budget,
                          output int done_cyc, output int busy_cnt, output int req_cnt);
    logic [31:0] sa, da;
    sa = src & ~32'd3;
    da = dst & ~32'd3;
    for (int i = 0; i < n_exp; i++) begin
      wr_t e;
      e.a = da + 32'(4 * i);
      e.d = mem[sa + 32'(4 * i)];
      exp_q.push_back(e);
    end
    rd_log.delete();
    @(negedge clk);
    start = 1'b1; src_addr = src; dst_addr = dst; len_words = len;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1; busy_cnt = 0; req_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (dma_mem_req) req_cnt++;
      abort = (k == abort_cyc);
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    abort = 1'b0;
    if (done_cyc < 0) check_eq("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  int dc, bc, rc;

  initial begin
    fill(32'h0000_0100, 3, 32'hA000_0001);
    fill(32'h0000_0200, 4, 32'hB000_0002);
    fill(32'hFFFF_FFFC, 1, 32'hC000_0003);
    fill(32'h0000_0000, 1, 32'hD000_0004);
    fill(32'h0000_0500, 3, 32'hE000_0005);

    repeat (2) @(negedge clk);
    check_eq("rst_req", 64'(dma_mem_req), 64'd0);
    check_eq("rst_outs", {10'd0, busy, done, words_left, dma_mem_bytesel, dma_mem_addr}, 64'd0);
    check_eq("rst_wdata", 64'(dma_mem_wdata), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic three-word copy
    run_copy(32'h100, 32'h8200, 16'd3, 3, 0, 40, dc, bc, rc);
    check_eq("t1_done_cyc", 64'(dc), 64'd10);
    check_eq("t1_busy_cnt", 64'(bc), 64'd9);
    check_eq("t1_req_cnt", 64'(rc), 64'd9);
    check_eq("t1_words_left", 64'(words_left), 64'd0);
    check_eq("t1_mem", 64'(mem[32'h8208]), 64'(32'hA000_0001 + 32'd2 * 32'h0101_1111));

    // Zero-length copy
    run_copy(32'h100, 32'h8600, 16'd0, 0, 0, 10, dc, bc, rc);
    check_eq("t2_done_cyc", 64'(dc), 64'd1);
    check_eq("t2_busy_cnt", 64'(bc), 64'd0);
    check_eq("t2_req_cnt", 64'(rc), 64'd0);

    // Stalled read ack, unaligned addresses
    stall_cfg = 5;
    run_copy(32'h101, 32'h8303, 16'd2, 2, 0, 60, dc, bc, rc);
    stall_cfg = 0;
    check_eq("t3_done_cyc", 64'(dc), 64'd17);
    check_eq("t3_busy_cnt", 64'(bc), 64'd16);
    check_eq("t3_rd_addr1", 64'(rd_log.size() == 2 ? rd_log[1] : 32'hDEAD), 64'h104);

    // Abort during the second read
    run_copy(32'h200, 32'h8400, 16'd4, 2, 4, 40, dc, bc, rc);
    check_eq("t4_done_cyc", 64'(dc), 64'd7);
    check_eq("t4_words_left", 64'(words_left), 64'd2);
    check_eq("t4_no_more", 64'(rd_log.size()), 64'd2);

    // Source address wrap
    run_copy(32'hFFFF_FFFC, 32'h300, 16'd2, 2, 0, 40, dc, bc, rc);
    check_eq("t5_done_cyc", 64'(dc), 64'd7);
    check_eq("t5_rd_addr1", 64'(rd_log.size() == 2 ? rd_log[1] : 32'hDEAD), 64'h0);

    // Reset asserted during WR
    exp_q.push_back('{a: 32'h9000, d: mem[32'h500]});
    @(negedge clk);
    start = 1'b1; src_addr = 32'h500; dst_addr = 32'h9000; len_words = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_in_wr", {63'd0, dma_mem_req && dma_mem_bytesel == 4'hF}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_req_drop", 64'(dma_mem_req), 64'd0);
    check_eq("t6_outs", {10'd0, busy, done, words_left, dma_mem_bytesel, dma_mem_addr}, 64'd0);
    check_eq("t6_wdata", 64'(dma_mem_wdata), 64'd0);
    check_eq("t6_sb", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || dma_mem_req || done) bc++;
    end
    check_eq("t6_idle", 64'(bc), 64'd0);
    run_copy(32'h100, 32'h8800, 16'd3, 3, 0, 40, dc, bc, rc);
    check_eq("t6_done_cyc", 64'(dc), 64'd10);
    check_eq("t6_busy_cnt", 64'(bc), 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
